// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter committing one requester's write data into a shared register.
// Optional force/release override of q is compiled in with `define REG_ARB_FORCE_EN.
module reg_write_arbiter #(
  parameter int N_REQ = 4,
  parameter int DW    = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [N_REQ-1:0]   req,
  input  logic [N_REQ*DW-1:0] wdata,
  input  logic               force_en,
  input  logic [DW-1:0]      force_val,
  output logic [N_REQ-1:0]   gnt,
  output logic [DW-1:0]      q,
  output logic               busy,
  output logic               forced,
  output logic [15:0]        wr_count
);

  localparam int PW = $clog2(N_REQ);

`ifdef REG_ARB_FORCE_EN
  typedef enum logic [1:0] {IDLE, GRANT, FORCED} state_t;
`else
  typedef enum logic [1:0] {IDLE, GRANT} state_t;
`endif

  state_t           state_reg;
  logic [PW-1:0]    ptr_reg;
  logic [PW-1:0]    win_reg;
  logic [PW-1:0]    win_next;
  logic [PW-1:0]    ptr_next;
  logic             win_valid;
  logic [N_REQ-1:0] gnt_reg;
  logic [N_REQ-1:0] gnt_next;
  logic [DW-1:0]    shadow_reg;
  logic [DW-1:0]    commit_data;
  logic [15:0]      wr_count_reg;
  logic [DW-1:0]    wdata_arr [N_REQ];
  int               sel_idx;

  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign wdata_arr[gi] = wdata[gi*DW +: DW];
    end
  endgenerate

  // Scan offsets high to low so the requester closest to ptr wins.
  always_comb begin
    win_valid = 1'b0;
    win_next  = ptr_reg;
    sel_idx   = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      sel_idx = (int'(ptr_reg) + k) % N_REQ;
      if (req[sel_idx]) begin
        win_valid = 1'b1;
        win_next  = PW'(sel_idx);
      end
    end
  end

  assign gnt_next    = {{(N_REQ-1){1'b0}}, 1'b1} << win_next;
  assign ptr_next    = (win_reg == PW'(N_REQ - 1)) ? '0 : win_reg + 1'b1;
  assign commit_data = wdata_arr[win_reg];

`ifdef REG_ARB_FORCE_EN
  logic [DW-1:0] q_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      win_reg      <= '0;
      gnt_reg      <= '0;
      shadow_reg   <= '0;
      q_reg        <= '0;
      wr_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (force_en) begin
            state_reg <= FORCED;
            q_reg     <= force_val;
          end else if (win_valid) begin
            state_reg <= GRANT;
            gnt_reg   <= gnt_next;
            win_reg   <= win_next;
          end
        end
        GRANT: begin
          // The write commits even if an override starts on this edge.
          gnt_reg      <= '0;
          shadow_reg   <= commit_data;
          wr_count_reg <= wr_count_reg + 16'd1;
          ptr_reg      <= ptr_next;
          if (force_en) begin
            state_reg <= FORCED;
            q_reg     <= force_val;
          end else begin
            state_reg <= IDLE;
            q_reg     <= commit_data;
          end
        end
        FORCED: begin
          if (force_en) begin
            q_reg <= force_val;
          end else begin
            state_reg <= IDLE;
            q_reg     <= shadow_reg;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign q      = q_reg;
  assign forced = (state_reg == FORCED);
`else
  logic unused_force;
  assign unused_force = ^{force_en, force_val};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      ptr_reg      <= '0;
      win_reg      <= '0;
      gnt_reg      <= '0;
      shadow_reg   <= '0;
      wr_count_reg <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            state_reg <= GRANT;
            gnt_reg   <= gnt_next;
            win_reg   <= win_next;
          end
        end
        GRANT: begin
          state_reg    <= IDLE;
          gnt_reg      <= '0;
          shadow_reg   <= commit_data;
          wr_count_reg <= wr_count_reg + 16'd1;
          ptr_reg      <= ptr_next;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign q      = shadow_reg;
  assign forced = 1'b0;
`endif

  assign gnt      = gnt_reg;
  assign busy     = (state_reg != IDLE);
  assign wr_count = wr_count_reg;

endmodule
